// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg: shared definitions for the fetch, branch and imem blocks.
//   XLEN         - address width in bits
//   RESET_VECTOR - default PC loaded while reset is asserted
//   IALIGN       - instruction alignment in bytes (2 or 4)
//   addr_t       - XLEN-wide address type
//   is_aligned() - true when the low log2(ialign) bits of an address are 0
// ---------------------------------------------------------------------------
package core_pkg;

    parameter int unsigned XLEN         = 32;
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000;
    parameter int unsigned IALIGN       = 4;

    typedef logic [XLEN-1:0] addr_t;

    // Only the low bits matter, so the check is valid for any ialign that
    // is a power of two no larger than the address width.
    function automatic logic is_aligned(addr_t a, int unsigned ialign = IALIGN);
        addr_t mask;
        mask = addr_t'(ialign - 1);
        return (a & mask) == '0;
    endfunction

endpackage

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter: architectural PC register for the fetch stage.
//
// Loads the next-PC chosen upstream on every unstalled rising edge; holds
// on stall. No internal incrementing: PC_out only changes by load or reset.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   PC_in        in   next-PC value to load
//   stall        in   1 = hold PC this cycle
//   PC_out       out  current PC (registered)
//   pc_plus4     out  PC_out + 4, modulo 2^XLEN (combinational)
//   pc_valid     out  high from the first edge after reset release
//   misalign_err out  one-cycle pulse when a misaligned PC_in is rejected
//
// Build option:
//   PC_ALIGN_CHECK_EN - defined:   misaligned loads are rejected (PC holds,
//                                  misalign_err pulses)
//                       undefined: low alignment bits are masked to zero and
//                                  misalign_err is tied to 0
// ---------------------------------------------------------------------------
module program_counter
    import core_pkg::*;
#(
    parameter int unsigned      XLEN         = core_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(core_pkg::RESET_VECTOR),
    parameter int unsigned      IALIGN       = core_pkg::IALIGN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_in,
    input  logic            stall,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);

    // Elaboration-time parameter sanity.
    if (IALIGN != 2 && IALIGN != 4) begin : g_bad_ialign
        $error("program_counter: IALIGN must be 2 or 4");
    end
    if ((RESET_VECTOR & LOW_MASK) != '0) begin : g_bad_rv
        $error("program_counter: RESET_VECTOR must be IALIGN-aligned");
    end

    // Truncation/extension into addr_t keeps the low bits, which is all the
    // alignment check looks at.
    logic pc_in_aligned;
    assign pc_in_aligned = is_aligned(addr_t'(PC_in), IALIGN);

    // Wraps naturally at 2^XLEN; no carry-out is exposed.
    assign pc_plus4 = PC_out + XLEN'(4);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_out     <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (stall) begin
                // PC_in is ignored entirely while stalled.
                misalign_q <= 1'b0;
            end else if (pc_in_aligned) begin
                PC_out     <= PC_in;
                misalign_q <= 1'b0;
            end else begin
                // Reject: keep the old PC and flag for this cycle only.
                misalign_q <= 1'b1;
            end
        end
    end

    assign misalign_err = misalign_q;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_out   <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            pc_valid <= 1'b1;
            if (!stall) begin
                PC_out <= PC_in & ~LOW_MASK;
            end
        end
    end

    // The check result only matters when rejection is enabled.
    logic unused_aligned;
    assign unused_aligned = pc_in_aligned;

    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter: scoreboard bench for program_counter.
// Expected state is computed by a small reference model when stimulus is
// driven, pushed to a queue, and compared after the DUT edge.
// ---------------------------------------------------------------------------
module tb_program_counter;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        valid;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] PC_in;
    logic        stall;
    logic [31:0] PC_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_err;

    program_counter dut (
        .clk          (clk),
        .reset        (reset),
        .PC_in        (PC_in),
        .stall        (stall),
        .PC_out       (PC_out),
        .pc_plus4     (pc_plus4),
        .pc_valid     (pc_valid),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.pc    = m_pc;
        e.plus4 = m_pc + 32'd4;
        e.valid = m_valid;
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".pc"},    PC_out,              e.pc);
        chk({e.tag, ".plus4"}, pc_plus4,            e.plus4);
        chk({e.tag, ".valid"}, {31'd0, pc_valid},     {31'd0, e.valid});
        chk({e.tag, ".err"},   {31'd0, misalign_err}, {31'd0, e.err});
    endtask

    // Model the effect of the coming rising edge.
    task automatic model_edge(input logic [31:0] pin, input logic st);
        if (!reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            m_valid = 1'b1;
            if (st) begin
                m_err = 1'b0;
            end else begin
`ifdef PC_ALIGN_CHECK_EN
                if (pin[1:0] != 2'b00) begin
                    m_err = 1'b1;
                end else begin
                    m_pc  = pin;
                    m_err = 1'b0;
                end
`else
                m_pc  = {pin[31:2], 2'b00};
                m_err = 1'b0;
`endif
            end
        end
    endtask

    // Drive at negedge, let one rising edge happen, compare just after it.
    task automatic cycle(input logic [31:0] pin, input logic st, input logic rst_val, input string tag);
        @(negedge clk);
        PC_in = pin;
        stall = st;
        reset = rst_val;
        if (!reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        end
        model_edge(pin, st);
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    initial begin
        reset = 1'b0;
        PC_in = 32'h40;
        stall = 1'b0;
        m_pc = 32'h0; m_valid = 1'b0; m_err = 1'b0;

        // Reset held across edges
        #1;
        push_exp("rst_initial");
        pop_cmp();
        cycle(32'h40, 1'b0, 1'b0, "rst_hold0");
        cycle(32'h40, 1'b0, 1'b0, "rst_hold1");

        // Release: first edge loads 0x40 and raises pc_valid
        cycle(32'h40, 1'b0, 1'b1, "rst_release");

        // Sequential loads
        for (int i = 0; i < 4; i++)
            cycle(32'(i * 4), 1'b0, 1'b1, $sformatf("seq%0d", i));

        // Stall for 3 cycles with a different PC_in
        cycle(32'h100, 1'b0, 1'b1, "stall_pre");
        for (int i = 0; i < 3; i++)
            cycle(32'h200, 1'b1, 1'b1, $sformatf("stall%0d", i));
        cycle(32'h200, 1'b0, 1'b1, "stall_drop");

        // Async reset between edges
        cycle(32'h80, 1'b0, 1'b1, "async_pre");
        @(negedge clk);
        #2;
        reset = 1'b0;
        m_pc = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        #1;
        push_exp("async_rst");
        pop_cmp();
        // Reset overrides an unstalled load on the same edge
        cycle(32'h300, 1'b0, 1'b0, "async_hold");
        cycle(32'h300, 1'b0, 1'b1, "async_release");

        // Wrap-around
        cycle(32'hFFFF_FFFC, 1'b0, 1'b1, "wrap_load");
        cycle(pc_plus4, 1'b0, 1'b1, "wrap_next");

        // Misaligned input
        cycle(32'h200, 1'b0, 1'b1, "mis_pre");
        cycle(32'h102, 1'b0, 1'b1, "mis0");
        cycle(32'h107, 1'b0, 1'b1, "mis1");
        cycle(32'h103, 1'b1, 1'b1, "mis_stalled");
        cycle(32'h102, 1'b0, 1'b1, "mis2");
        cycle(32'h104, 1'b0, 1'b1, "mis_clear");

        // Random traffic
        for (int i = 0; i < 40; i++)
            cycle($urandom, 1'($urandom_range(0, 3) == 0), 1'b1, $sformatf("rnd%0d", i));

        if (sb.size() != 0) chk("scoreboard_left", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Architectural program counter register for the RISC-V core's fetch stage.
- Holds the current instruction address and loads the next-PC value chosen upstream (PC+4, branch or jump target) on each clock edge.
- Supports stall/hold, a reset vector, a sequential-address output and an optional instruction-alignment check.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value while reset is asserted and after release.
- IALIGN, 4, instruction alignment in bytes; legal values 2 or 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- PC_in  input  XLEN  next-PC value to load.
- stall  input  1  1 = hold the current PC this cycle; 0 = load PC_in.
- PC_out  output  XLEN  current PC, registered.
- pc_plus4  output  XLEN  PC_out + 4, combinational.
- pc_valid  output  1  high from the first clock edge after reset release.
- misalign_err  output  1  one-cycle pulse when a misaligned PC_in is rejected; tied to 0 without the optional feature.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - PC_out=RESET_VECTOR immediately.
  - pc_valid=0 and misalign_err=0.
  - pc_plus4=RESET_VECTOR+4.
- Reset release: takes effect synchronously at the next rising edge. On that edge, pc_valid<=1 and the normal load rules below apply.
- pc_valid stays 1 until the next reset assertion.
- Rising edge with reset=1 and stall=1:
  - PC_out holds its value.
  - misalign_err<=0.
  - PC_in is ignored, including any alignment check.
- Rising edge with reset=1 and stall=0: PC_out<=PC_in, subject to the alignment rules below. Latency is one cycle: a PC_in value is visible on PC_out after the edge that samples it.
- pc_plus4 is purely combinational from PC_out. Addition is modulo 2^XLEN, so 32'hFFFF_FFFC gives 32'h0000_0000 with no carry-out or flag.
- No internal incrementing: PC_out changes only by loading PC_in or by reset.
- Reset asserted mid-operation overrides stall and any pending load in the same cycle.
- Alignment with PC_ALIGN_CHECK_EN undefined: the low log2(IALIGN) bits of PC_in are forced to 0 on load.
- RESET_VECTOR must itself be IALIGN-aligned; elaboration-time assertion.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - On an unstalled edge where PC_in[log2(IALIGN)-1:0] != 0, PC_out holds its old value and misalign_err<=1 for exactly one cycle.
  - An aligned load on the next edge clears misalign_err.
  - Back-to-back misaligned inputs keep misalign_err high each such cycle.
- Undefined:
  - Low bits are silently masked as above.
  - misalign_err is constant 0.

Decomposition:
- Shared package (core_pkg): XLEN, RESET_VECTOR default, IALIGN, and a typedef addr_t = logic [XLEN-1:0]. These are reused by the fetch, branch and imem blocks.
- A single module; no sub-module needed.
- The +4 adder stays inline; the alignment check is an inline function in the package (is_aligned(addr_t)).

Test Plan:
- Reset: hold reset=0 with PC_in=32'h0000_0040 across edges -> PC_out=0, pc_plus4=4, pc_valid=0. Release reset -> first edge gives PC_out=32'h40, pc_valid=1.
- Sequential load: PC_in=0,4,8,12 on consecutive unstalled edges -> PC_out trails PC_in by one cycle, and pc_plus4 is always PC_out+4.
- Stall: PC_out=32'h100, stall=1 for 3 cycles while PC_in=32'h200 -> PC_out stays 32'h100. Drop stall -> next edge gives 32'h200.
- Async reset mid-run: PC_out=32'h80, assert reset between edges -> PC_out=0 immediately without a clock edge, and pc_valid=0.
- Wrap-around: load 32'hFFFF_FFFC -> pc_plus4=0. Feed PC_in=pc_plus4 -> PC_out=0 next cycle.
- Misaligned PC_in=32'h0000_0102 (IALIGN=4):
  - With PC_ALIGN_CHECK_EN: PC_out holds its prior value, misalign_err=1 for one cycle.
  - Without it: PC_out=32'h0000_0100, misalign_err=0.
